conv_loop_controller: RTL

Sequencer for the convolution datapath: on `start` it walks the full loop nest (output row, output column, output channel, input channel, kernel row, kernel column) and issues one MAC step per handshake to the datapath. For each step it supplies output/input coordinates, kernel indices, padding and accumulator control flags. After the last step of each output pixel/channel it presents one output-valid handshake with the output coordinates. It sits inside `top_system` between the start/running control interface and the MAC/accumulator datapath.

---
 rtl/conv_loop_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/conv_loop_controller.sv
// Loop-nest sequencer for the convolution datapath: walks y, x, ch_out, ch_in, ky, kx
// and issues one MAC step per handshake, then one result handshake per output pixel/channel.
module conv_loop_controller #(
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3,
  localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
  localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  start,
  input  logic                  conv_stride_mode,
  output logic                  running,
  output logic                  step_valid,
  input  logic                  step_ready,
  output logic [XW-1:0]         step_x,
  output logic [YW-1:0]         step_y,
  output logic [COW-1:0]        step_ch_out,
  output logic [CIW-1:0]        step_ch_in,
  output logic [KW-1:0]         step_kx,
  output logic [KW-1:0]         step_ky,
  output logic signed [XW+1:0]  in_x,
  output logic signed [YW+1:0]  in_y,
  output logic                  pad,
  output logic                  acc_clear,
  output logic                  acc_last,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [XW-1:0]         output_x,
  output logic [YW-1:0]         output_y,
  output logic [COW-1:0]        output_ch
);

  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, OUT = 2'd2} state_t;

  localparam logic [XW-1:0]  X_LAST_S1 = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [XW-1:0]  X_LAST_S2 = XW'(FEATURE_MAP_WIDTH / 2 - 1);
  localparam logic [YW-1:0]  Y_LAST_S1 = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [YW-1:0]  Y_LAST_S2 = YW'(FEATURE_MAP_HEIGHT / 2 - 1);
  localparam logic [COW-1:0] CO_LAST   = COW'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [CIW-1:0] CI_LAST   = CIW'(INPUT_NB_CHANNELS - 1);
  localparam logic [KW-1:0]  K_LAST    = KW'(KERNEL_SIZE - 1);

  localparam logic signed [XW+1:0] HALF_X = (XW+2)'((KERNEL_SIZE - 1) / 2);
  localparam logic signed [YW+1:0] HALF_Y = (YW+2)'((KERNEL_SIZE - 1) / 2);
  localparam logic signed [XW+1:0] MAP_W  = (XW+2)'(FEATURE_MAP_WIDTH);
  localparam logic signed [YW+1:0] MAP_H  = (YW+2)'(FEATURE_MAP_HEIGHT);

  state_t         state_q, state_d;
  logic           stride_q, stride_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [COW-1:0] co_q, co_d;
  logic [CIW-1:0] ci_q, ci_d;
  logic [KW-1:0]  ky_q, ky_d;
  logic [KW-1:0]  kx_q, kx_d;

  logic last_step, x_end, y_end, co_end;
  logic signed [XW+1:0] xs, kxs;
  logic signed [YW+1:0] ys, kys;

  assign last_step = (ci_q == CI_LAST) && (ky_q == K_LAST) && (kx_q == K_LAST);
  assign x_end     = (x_q == (stride_q ? X_LAST_S2 : X_LAST_S1));
  assign y_end     = (y_q == (stride_q ? Y_LAST_S2 : Y_LAST_S1));
  assign co_end    = (co_q == CO_LAST);

  // Stride 2 is a left shift of the output coordinate; kernel offset is centred.
  assign xs   = stride_q ? {1'b0, x_q, 1'b0} : {2'b00, x_q};
  assign ys   = stride_q ? {1'b0, y_q, 1'b0} : {2'b00, y_q};
  assign kxs  = {{(XW+2-KW){1'b0}}, kx_q};
  assign kys  = {{(YW+2-KW){1'b0}}, ky_q};
  assign in_x = xs + kxs - HALF_X;
  assign in_y = ys + kys - HALF_Y;

  assign running      = (state_q != IDLE);
  assign step_valid   = (state_q == STEP);
  assign output_valid = (state_q == OUT);
  assign acc_clear    = step_valid && (ci_q == '0) && (ky_q == '0) && (kx_q == '0);
  assign acc_last     = step_valid && last_step;
  assign pad          = step_valid && (in_x[XW+1] || (in_x >= MAP_W) ||
                                       in_y[YW+1] || (in_y >= MAP_H));

  assign step_x      = x_q;
  assign step_y      = y_q;
  assign step_ch_out = co_q;
  assign step_ch_in  = ci_q;
  assign step_kx     = kx_q;
  assign step_ky     = ky_q;
  assign output_x    = x_q;
  assign output_y    = y_q;
  assign output_ch   = co_q;

  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    x_d      = x_q;
    y_d      = y_q;
    co_d     = co_q;
    ci_d     = ci_q;
    ky_d     = ky_q;
    kx_d     = kx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          stride_d = conv_stride_mode;
          state_d  = STEP;
        end
      end
      STEP: begin
        if (step_ready) begin
          if (last_step) begin
            kx_d    = '0;
            ky_d    = '0;
            ci_d    = '0;
            state_d = OUT;
          end else if (kx_q != K_LAST) begin
            kx_d = kx_q + 1'b1;
          end else begin
            kx_d = '0;
            if (ky_q != K_LAST) begin
              ky_d = ky_q + 1'b1;
            end else begin
              ky_d = '0;
              ci_d = ci_q + 1'b1;
            end
          end
        end
      end
      OUT: begin
        if (output_ready) begin
          if (co_end && x_end && y_end) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            co_d    = '0;
          end else begin
            state_d = STEP;
            if (!co_end) begin
              co_d = co_q + 1'b1;
            end else begin
              co_d = '0;
              if (!x_end) begin
                x_d = x_q + 1'b1;
              end else begin
                x_d = '0;
                y_d = y_q + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q  <= IDLE;
      stride_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      co_q     <= '0;
      ci_q     <= '0;
      ky_q     <= '0;
      kx_q     <= '0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      x_q      <= x_d;
      y_q      <= y_d;
      co_q     <= co_d;
      ci_q     <= ci_d;
      ky_q     <= ky_d;
      kx_q     <= kx_d;
    end
  end

endmodule
